// File: rtl/bus_fifo_pkg.sv
// Shared constants for the simpleBUS FIFO slave: register offsets,
// flag and status bit positions, and the occupancy-count width helper.
// Ports: none (package).
package bus_fifo_pkg;

   // Register offsets, decoded from S_address[2:0]
   localparam logic [2:0] REG_DATA_W = 3'd0;
   localparam logic [2:0] REG_DATA_R = 3'd1;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_FLAGS  = 3'd4;

   // FLAGS register bit positions
   localparam int FLAG_OVF = 0;
   localparam int FLAG_UNF = 1;

   // STATUS register bit positions; count starts at STAT_CNT_LSB
   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_CNT_LSB = 2;

   // Occupancy counter width: one bit more than the pointer so that
   // count == DEPTH is representable.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_core.sv
// Purpose: DEPTH-entry FIFO storage with pointers and occupancy count.
// Latency: push/pop/clr take effect at the next edge; dout shows the head combinationally.
// Backpressure: none; push when full and pop when empty are ignored (caller flags them).
// Ports: clk, reset_n (async active-low), push/pop/clr strobes, din, dout (head),
//        full, empty, count.
module fifo_core
   import bus_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int CW         = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic [CW-1:0]         count
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         count_d  = count_q + 1'b1;
      end else if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         count_d  = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (do_push && !clr) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/bus_fifo_slave.sv
// Purpose: simpleBUS slave buffering master writes in a FIFO, with status/ctrl/flags regs.
// Latency: every transfer completes in one cycle; read data appears on S_dout after the sampling edge.
// Backpressure: none, every transfer is accepted; pushes into a full FIFO drop data and set ovf.
// Ports: clk, reset_n (async active-low), S_sel/S_wr/S_address/S_din from the master,
//        S_dout registered read data, irq = ovf | unf (registered).
module bus_fifo_slave
   import bus_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  S_sel,
   input  logic                  S_wr,
   input  logic [ADDR_WIDTH-1:0] S_address,
   input  logic [DATA_WIDTH-1:0] S_din,
   output logic [DATA_WIDTH-1:0] S_dout,
   output logic                  irq
);

   localparam int CW = cnt_width(DEPTH);

   logic [2:0]            offset;
   logic                  wr_xfer, rd_xfer;
   logic                  push, pop, clr, flags_wr;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic [DATA_WIDTH-1:0] status_w;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  irq_q;
   logic                  unused_addr;

   // Only the low three address bits select a register.
   assign offset      = S_address[2:0];
   assign unused_addr = ^S_address[ADDR_WIDTH-1:3];

   assign wr_xfer  = S_sel && S_wr;
   assign rd_xfer  = S_sel && !S_wr;
   assign push     = wr_xfer && (offset == REG_DATA_W);
   assign pop      = rd_xfer && (offset == REG_DATA_R);
   assign clr      = wr_xfer && (offset == REG_CTRL) && S_din[0];
   assign flags_wr = wr_xfer && (offset == REG_FLAGS);

   fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CW         (CW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .clr     (clr),
      .din     (S_din),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      status_w                               = '0;
      status_w[STAT_EMPTY]                   = fifo_empty;
      status_w[STAT_FULL]                    = fifo_full;
      status_w[STAT_CNT_LSB+CW-1:STAT_CNT_LSB] = fifo_count;
   end

   // Sticky flags. A set event and a W1C are always different transfers,
   // so applying them in sequence here never loses an event.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (push && fifo_full) begin
         ovf_d = 1'b1;
      end
      if (pop && fifo_empty) begin
         unf_d = 1'b1;
      end
      if (flags_wr) begin
         if (S_din[FLAG_OVF]) ovf_d = 1'b0;
         if (S_din[FLAG_UNF]) unf_d = 1'b0;
      end
   end

   // Read mux; idle and write cycles return zero.
   always_comb begin
      dout_d = '0;
      if (rd_xfer) begin
         case (offset)
            REG_DATA_R: dout_d = fifo_empty ? '0 : fifo_dout;
            REG_STATUS: dout_d = status_w;
            REG_FLAGS: begin
               dout_d[FLAG_OVF] = ovf_q;
               dout_d[FLAG_UNF] = unf_q;
            end
            default:    dout_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         // Built from next-state flags so irq tracks the flags with no extra delay.
         irq_q  <= ovf_d | unf_d;
      end
   end

   assign S_dout = dout_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Directed self-checking bench for bus_fifo_slave (DATA_WIDTH=32, ADDR_WIDTH=8, DEPTH=8).
module tb_bus_fifo_slave;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        S_sel;
   logic        S_wr;
   logic [7:0]  S_address;
   logic [31:0] S_din;
   logic [31:0] S_dout;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   bus_fifo_slave #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (8),
      .DEPTH      (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .S_sel     (S_sel),
      .S_wr      (S_wr),
      .S_address (S_address),
      .S_din     (S_din),
      .S_dout    (S_dout),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One bus transfer: drive, let the edge sample it, look #1 later.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] din);
      S_sel     = 1'b1;
      S_wr      = wr;
      S_address = addr;
      S_din     = din;
      @(posedge clk);
      #1;
      S_sel = 1'b0;
      S_wr  = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] din);
      xfer(1'b1, addr, din);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      xfer(1'b0, addr, 32'h0);
      chk(tag, S_dout, exp);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      S_sel     = 1'b0;
      S_wr      = 1'b0;
      S_address = '0;
      S_din     = '0;
      #12;
      chk("rst_dout", S_dout, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-stream after three pushes
      wr(8'd0, 32'h1);
      wr(8'd0, 32'h2);
      wr(8'd0, 32'h3);
      rd_chk("pre_rst_status", 8'd2, 32'h0000_000C);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_dout", S_dout, 32'h0);
      chk("mid_rst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      rd_chk("post_rst_status", 8'd2, 32'h1);
      chk("post_rst_irq", {31'h0, irq}, 32'h0);

      // Ordering; upper address bits are not decoded
      wr(8'h40, 32'h11);
      wr(8'h80, 32'h22);
      wr(8'h00, 32'h33);
      rd_chk("ord0", 8'd1, 32'h11);
      rd_chk("ord1", 8'hF9, 32'h22);
      rd_chk("ord2", 8'd1, 32'h33);
      idle();
      chk("idle_dout", S_dout, 32'h0);
      rd_chk("ord_status", 8'd2, 32'h1);
      wr(8'd0, 32'h5555);
      chk("wrcyc_dout", S_dout, 32'h0);
      rd_chk("dataw_read", 8'd0, 32'h0);
      wr(8'd1, 32'h9999);
      rd_chk("pop_after_datar_wr", 8'd1, 32'h5555);
      rd_chk("empty_again", 8'd2, 32'h1);

      // Full and overflow
      for (int i = 0; i < 8; i++) wr(8'd0, i);
      rd_chk("full_status", 8'd2, 32'h22);
      wr(8'd0, 32'hDEAD);
      chk("ovf_irq", {31'h0, irq}, 32'h1);
      rd_chk("ovf_flags", 8'd4, 32'h1);
      rd_chk("ovf_status", 8'd2, 32'h22);
      for (int i = 0; i < 8; i++) rd_chk($sformatf("drain%0d", i), 8'd1, i);
      rd_chk("drain_status", 8'd2, 32'h1);
      wr(8'd4, 32'h1);
      chk("ovf_clr_irq", {31'h0, irq}, 32'h0);
      rd_chk("ovf_clr_flags", 8'd4, 32'h0);

      // Underflow and W1C
      rd_chk("unf_dout", 8'd1, 32'h0);
      chk("unf_irq", {31'h0, irq}, 32'h1);
      rd_chk("unf_flags", 8'd4, 32'h2);
      wr(8'd4, 32'h1);
      rd_chk("w1c_other_bit", 8'd4, 32'h2);
      chk("w1c_other_irq", {31'h0, irq}, 32'h1);
      wr(8'd4, 32'h2);
      chk("w1c_irq", {31'h0, irq}, 32'h0);
      rd_chk("w1c_flags", 8'd4, 32'h0);

      // Wrap-around
      for (int i = 0; i < 6; i++) wr(8'd0, 32'h50 + i);
      for (int i = 0; i < 6; i++) rd_chk($sformatf("pre_wrap%0d", i), 8'd1, 32'h50 + i);
      for (int i = 0; i < 6; i++) wr(8'd0, 32'hA0 + i);
      rd_chk("wrap_status", 8'd2, 32'h18);
      for (int i = 0; i < 6; i++) rd_chk($sformatf("wrap%0d", i), 8'd1, 32'hA0 + i);
      rd_chk("wrap_empty", 8'd2, 32'h1);

      // Soft clear and unmapped offsets
      for (int i = 0; i < 4; i++) wr(8'd0, 32'hC0 + i);
      rd_chk("pre_clr_status", 8'd2, 32'h10);
      wr(8'd3, 32'h0);
      rd_chk("ctrl0_status", 8'd2, 32'h10);
      rd_chk("ctrl_read", 8'd3, 32'h0);
      wr(8'd3, 32'h1);
      rd_chk("clr_status", 8'd2, 32'h1);
      wr(8'd6, 32'hFFFF_FFFF);
      rd_chk("unmapped6", 8'd6, 32'h0);
      rd_chk("unmapped_status", 8'd2, 32'h1);
      rd_chk("clr_pop", 8'd1, 32'h0);
      rd_chk("clr_unf_flags", 8'd4, 32'h2);
      chk("clr_unf_irq", {31'h0, irq}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
